// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: address map, Zicsr funct3 codes, trap causes, bit positions.
// Latency: none; declarations only.
// Backpressure: not applicable.
package csr_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    // Writable counter halves and their read-only user aliases
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // Zicsr funct3 encodings; bit 2 selects the immediate form
    typedef enum logic [2:0] {
        F3_RW  = 3'b001,
        F3_RS  = 3'b010,
        F3_RC  = 3'b011,
        F3_RWI = 3'b101,
        F3_RSI = 3'b110,
        F3_RCI = 3'b111
    } csr_f3_e;

    // mcause values
    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;
    localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;

    // Bit positions inside mstatus / mie / mip
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIE_MTIE_BIT     = 7;
    localparam int MIE_MEIE_BIT     = 11;

endpackage

// File: rtl/csr_counter_m.sv
// Free-running event counter of CNT_WIDTH bits with 32-bit lo/hi software write ports, zero-extended to 64 bits.
// Latency: increments and writes become visible the cycle after the clock edge.
// Backpressure: none; a write to either half replaces that cycle's increment of the whole counter.
module csr_counter_m #(
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdat,
    output logic [63:0] o_cnt
);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Half writes take precedence over the increment; the counter wraps at 2^CNT_WIDTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_wr_lo) begin
            r_cnt <= {r_cnt[CNT_WIDTH-1:32], i_wdat};
        end else if (i_wr_hi) begin
            r_cnt <= {i_wdat[CNT_WIDTH-33:0], r_cnt[31:0]};
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_cnt = 64'(r_cnt);

endmodule

// File: rtl/csr_unit_m.sv
// Machine-mode CSR unit: Zicsr access, ECALL/interrupt trap entry, MRET, mcycle/minstret (CSR_COUNTERS_EN).
// Latency: read data and redirects are combinational; state updates land on the next clock edge; irqs pend 1 cycle after rising.
// Backpressure: pipeline_en=0 freezes architectural state (mcycle and mip sampling keep running) and masks redirects.
module csr_unit_m
    import csr_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = 64,
    parameter bit          MTVEC_VECTORED = 1'b1,
    parameter logic [31:0] RESET_MTVEC    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_en,
    input  logic        csr_we,
    input  logic [2:0]  func3,
    input  logic [4:0]  rs1,
    input  logic [31:0] src1,
    input  logic [31:0] pc,
    input  logic [11:0] csr_addr,
    input  logic        ecall,
    input  logic        mret,
    input  logic        instr_retire,
    input  logic        irq_timer,
    input  logic        irq_ext,
    output logic [31:0] csr,
    output logic        trap_taken,
    output logic [31:0] trap_target,
    output logic        mret_taken,
    output logic [31:0] mepc_out,
    output logic [31:0] mtvec_out
);

    // Bit 1 of mtvec is always 0; bit 0 (vectored mode) survives only when vectoring is built in
    localparam logic [31:0] MTVEC_MASK = MTVEC_VECTORED ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

    logic        r_mst_mie, r_mst_mpie, r_mie_mtie, r_mie_meie, r_mip_mtip, r_mip_meip;
    logic [31:0] r_mtvec, r_mscratch, r_mcause;
    logic [29:0] r_mepc;

    logic [31:0] w_mstatus, w_mie, w_mip, w_rdata, w_op, w_wdat, w_cause, w_vec_off;
    logic        w_irq_ext, w_irq_tmr, w_irq, w_wr_ok, w_csr_wr;
    logic [63:0] w_cyc, w_ins;
    logic        w_unused;

    // MPP is hardwired to machine mode, so mstatus reads 0x1800 with both enables clear
    assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mst_mpie, 3'b0, r_mst_mie, 3'b0};
    assign w_mie     = {20'b0, r_mie_meie, 3'b0, r_mie_mtie, 7'b0};
    assign w_mip     = {20'b0, r_mip_meip, 3'b0, r_mip_mtip, 7'b0};

    assign w_irq_ext = r_mip_meip & r_mie_meie & r_mst_mie;
    assign w_irq_tmr = r_mip_mtip & r_mie_mtie & r_mst_mie;
    assign w_irq     = w_irq_ext | w_irq_tmr;
    assign w_cause   = w_irq_ext ? CAUSE_M_EXT : (w_irq_tmr ? CAUSE_M_TIMER : CAUSE_ECALL_M);
    assign w_vec_off = (MTVEC_VECTORED && r_mtvec[0] && w_irq) ? {w_cause[29:0], 2'b00} : 32'h0;

    // Interrupt beats ECALL beats MRET beats a CSR write; a stall masks everything
    assign trap_taken  = pipeline_en & (w_irq | ecall);
    assign mret_taken  = pipeline_en & mret & ~trap_taken;
    assign w_csr_wr    = pipeline_en & csr_we & w_wr_ok & ~w_irq & ~ecall & ~mret;
    assign trap_target = {r_mtvec[31:2], 2'b00} + w_vec_off;
    assign csr         = w_rdata;
    assign mepc_out    = {r_mepc, 2'b00};
    assign mtvec_out   = r_mtvec;

`ifdef CSR_COUNTERS_EN
    csr_counter_m #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (1'b1),
        .i_wr_lo (w_csr_wr && (csr_addr == CSR_MCYCLE)),
        .i_wr_hi (w_csr_wr && (csr_addr == CSR_MCYCLEH)),
        .i_wdat  (w_wdat),
        .o_cnt   (w_cyc)
    );

    csr_counter_m #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (pipeline_en & instr_retire & ~trap_taken),
        .i_wr_lo (w_csr_wr && (csr_addr == CSR_MINSTRET)),
        .i_wr_hi (w_csr_wr && (csr_addr == CSR_MINSTRETH)),
        .i_wdat  (w_wdat),
        .o_cnt   (w_ins)
    );

    assign w_unused = ^pc[1:0];
`else
    assign w_cyc    = 64'h0;
    assign w_ins    = 64'h0;
    assign w_unused = ^{pc[1:0], instr_retire, w_cyc, w_ins};
`endif

    // Read mux returning the pre-update value; unmapped addresses read 0
    always_comb begin
        w_rdata = 32'h0;
        case (csr_addr)
            CSR_MSTATUS:  w_rdata = w_mstatus;
            CSR_MIE:      w_rdata = w_mie;
            CSR_MTVEC:    w_rdata = r_mtvec;
            CSR_MSCRATCH: w_rdata = r_mscratch;
            CSR_MEPC:     w_rdata = {r_mepc, 2'b00};
            CSR_MCAUSE:   w_rdata = r_mcause;
            CSR_MIP:      w_rdata = w_mip;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE,    CSR_CYCLE:    w_rdata = w_cyc[31:0];
            CSR_MCYCLEH,   CSR_CYCLEH:   w_rdata = w_cyc[63:32];
            CSR_MINSTRET,  CSR_INSTRET:  w_rdata = w_ins[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: w_rdata = w_ins[63:32];
`endif
            default:      w_rdata = 32'h0;
        endcase
    end

    // Zicsr write value; set/clear forms with a zero rs1/uimm do not write
    always_comb begin
        w_op    = func3[2] ? {27'b0, rs1} : src1;
        w_wdat  = w_op;
        w_wr_ok = 1'b0;
        case (func3)
            F3_RW, F3_RWI: begin
                w_wdat  = w_op;
                w_wr_ok = 1'b1;
            end
            F3_RS, F3_RSI: begin
                w_wdat  = w_rdata | w_op;
                w_wr_ok = (rs1 != 5'd0);
            end
            F3_RC, F3_RCI: begin
                w_wdat  = w_rdata & ~w_op;
                w_wr_ok = (rs1 != 5'd0);
            end
            default: begin
                w_wdat  = w_op;
                w_wr_ok = 1'b0;
            end
        endcase
    end

    // Interrupt lines are sampled every cycle, stalled or not
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mip_mtip <= 1'b0;
            r_mip_meip <= 1'b0;
        end else begin
            r_mip_mtip <= irq_timer;
            r_mip_meip <= irq_ext;
        end
    end

    // Architectural state: trap entry, then MRET, then software writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mst_mie  <= 1'b0;
            r_mst_mpie <= 1'b0;
            r_mie_mtie <= 1'b0;
            r_mie_meie <= 1'b0;
            r_mtvec    <= RESET_MTVEC & MTVEC_MASK;
            r_mscratch <= 32'h0;
            r_mepc     <= 30'h0;
            r_mcause   <= 32'h0;
        end else if (trap_taken) begin
            r_mepc     <= pc[31:2];
            r_mcause   <= w_cause;
            r_mst_mpie <= r_mst_mie;
            r_mst_mie  <= 1'b0;
        end else if (mret_taken) begin
            r_mst_mie  <= r_mst_mpie;
            r_mst_mpie <= 1'b1;
        end else if (w_csr_wr) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    r_mst_mie  <= w_wdat[MSTATUS_MIE_BIT];
                    r_mst_mpie <= w_wdat[MSTATUS_MPIE_BIT];
                end
                CSR_MIE: begin
                    r_mie_mtie <= w_wdat[MIE_MTIE_BIT];
                    r_mie_meie <= w_wdat[MIE_MEIE_BIT];
                end
                CSR_MTVEC:    r_mtvec    <= w_wdat & MTVEC_MASK;
                CSR_MSCRATCH: r_mscratch <= w_wdat;
                CSR_MEPC:     r_mepc     <= w_wdat[31:2];
                CSR_MCAUSE:   r_mcause   <= w_wdat;
                default: ;
            endcase
        end
    end

endmodule
